// File: rtl/fat_responder.sv
// fat_responder: forced assignment table serving implication/decision writers
// and a backtrack port that clears or reads single entries.
module fat_responder #(
   parameter int VAR_NUM     = 8,
   parameter int VAR_NUM_LOG = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fat_enable,
   input  logic                   fat_write,
   input  logic [VAR_NUM_LOG-1:0] fat_addr,
   input  logic                   imp_valid,
   input  logic [VAR_NUM_LOG-1:0] imp_var,
   input  logic                   imp_value,
   output logic                   imp_ready,
   input  logic                   dec_valid,
   input  logic [VAR_NUM_LOG-1:0] dec_var,
   input  logic                   dec_value,
   output logic                   dec_ready,
   output logic [VAR_NUM-1:0]     fat_out,
   output logic [VAR_NUM-1:0]     value_out,
   output logic [VAR_NUM-1:0]     implication_reg,
   output logic [1:0]             rd_data,
   output logic                   rd_valid,
   output logic                   conflict,
   output logic                   dec_err
);
   typedef enum logic [1:0] {IDLE, BACKTRACK, CONFLICT} state_t;
   localparam logic [VAR_NUM_LOG:0] LIMIT = (VAR_NUM_LOG+1)'(VAR_NUM);
   state_t state_q, state_d;
   logic [VAR_NUM-1:0] fat_q, fat_d, val_q, val_d, imp_q, imp_d;
   logic [1:0] rd_data_q, rd_data_d;
   logic rd_valid_q, rd_valid_d, dec_err_q, dec_err_d;
   logic addr_ok, imp_ok, dec_ok, clr, rd, imp_acc, dec_acc;
   assign addr_ok   = {1'b0, fat_addr} < LIMIT;
   assign imp_ok    = {1'b0, imp_var} < LIMIT;
   assign dec_ok    = {1'b0, dec_var} < LIMIT;
   assign clr       = fat_enable & fat_write;
   assign rd        = fat_enable & ~fat_write;
   assign imp_ready = rst & (state_q == IDLE) & ~fat_enable;
   assign dec_ready = imp_ready & ~imp_valid;
   assign imp_acc   = imp_valid & imp_ready & imp_ok;
   assign dec_acc   = dec_valid & dec_ready & dec_ok;
   always_comb begin
      fat_d      = fat_q;
      val_d      = val_q;
      imp_d      = imp_q;
      state_d    = state_q;
      dec_err_d  = 1'b0;
      rd_valid_d = rd;
      rd_data_d  = rd ? (addr_ok ? {fat_q[fat_addr], val_q[fat_addr]} : 2'b00) : rd_data_q;
      case (state_q)
         IDLE:      state_d = clr ? BACKTRACK : IDLE;
         CONFLICT:  state_d = clr ? BACKTRACK : CONFLICT;
         BACKTRACK: state_d = fat_enable ? BACKTRACK : IDLE;
         default:   state_d = IDLE;
      endcase
      if (clr && addr_ok) begin
         fat_d[fat_addr] = 1'b0;
         val_d[fat_addr] = 1'b0;
         imp_d[fat_addr] = 1'b0;
      end
      // implication and clear are mutually exclusive through imp_ready
      if (imp_acc) begin
         if (!fat_q[imp_var]) begin
            fat_d[imp_var] = 1'b1;
            val_d[imp_var] = imp_value;
            imp_d[imp_var] = 1'b1;
         end else if (val_q[imp_var] != imp_value) begin
            state_d = CONFLICT;
         end
      end
      if (dec_acc) begin
         if (!fat_q[dec_var]) begin
            fat_d[dec_var] = 1'b1;
            val_d[dec_var] = dec_value;
            imp_d          = '0;
         end else begin
            dec_err_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         fat_q      <= '0;
         val_q      <= '0;
         imp_q      <= '0;
         rd_data_q  <= 2'b00;
         rd_valid_q <= 1'b0;
         dec_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fat_q      <= fat_d;
         val_q      <= val_d;
         imp_q      <= imp_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         dec_err_q  <= dec_err_d;
      end
   end
   assign fat_out         = fat_q;
   assign value_out       = val_q;
   assign implication_reg = imp_q;
   assign rd_data         = rd_data_q;
   assign rd_valid        = rd_valid_q;
   assign conflict        = state_q == CONFLICT;
   assign dec_err         = dec_err_q;
endmodule
